// File: rtl/cla_addsub_seq_if.sv
// Request/response bundle for the sequential carry-lookahead adder/subtractor.
interface cla_addsub_seq_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, mode, a, b, cin,
        input  busy, done, s, cout, ovf, zero
    );

    modport slave (
        input  start, mode, a, b, cin,
        output busy, done, s, cout, ovf, zero
    );
endinterface

// File: rtl/cla_addsub_seq.sv
// Multi-cycle carry-lookahead adder/subtractor: resolves one BLK-bit lookahead
// block per clock and carries the inter-block carry in a register.
// Modes: 00 ADD, 01 SUB, 10 ADC, 11 SBB. For SUB/SBB cout=1 means no borrow.
module cla_addsub_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned BLK   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    cla_addsub_seq_if.slave bus
);
    localparam int unsigned NBLK = WIDTH / BLK;
    localparam int unsigned IW   = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBLK - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             creg_q, creg_d;
    logic             cmsb_q, cmsb_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] bx_q, bx_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    int unsigned      base;
    logic [BLK-1:0]   a_blk, b_blk, g, p, sum_blk;
    logic [BLK:0]     c_vec;
    logic             term, c_nxt;

    // Block lookahead: every carry is a flat sum of generate/propagate products.
    always_comb begin
        base    = 32'(idx_q) * BLK;
        a_blk   = a_q[base +: BLK];
        b_blk   = bx_q[base +: BLK];
        g       = a_blk & b_blk;
        p       = a_blk ^ b_blk;
        c_vec   = '0;
        term    = 1'b0;
        c_nxt   = 1'b0;
        c_vec[0] = creg_q;
        for (int i = 0; i < int'(BLK); i++) begin
            term = creg_q;
            for (int k = 0; k <= i; k++) begin
                term = term & p[k];
            end
            c_nxt = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                c_nxt = c_nxt | term;
            end
            c_vec[i+1] = c_nxt;
        end
        sum_blk = p ^ c_vec[BLK-1:0];
    end

    // Next-state, datapath and registered-output update.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        creg_d  = creg_q;
        cmsb_d  = cmsb_q;
        a_d     = a_q;
        bx_d    = bx_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    bx_d    = bus.mode[0] ? ~bus.b : bus.b;
                    creg_d  = bus.mode[1] ? bus.cin : bus.mode[0];
                    s_d     = '0;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                s_d[base +: BLK] = sum_blk;
                creg_d           = c_vec[BLK];
                if (idx_q == LAST_IDX) begin
                    cmsb_d  = c_vec[BLK-1];
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                cout_d  = creg_q;
                ovf_d   = cmsb_q ^ creg_q;
                zero_d  = (s_q == '0);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            creg_q  <= 1'b0;
            cmsb_q  <= 1'b0;
            a_q     <= '0;
            bx_q    <= '0;
            s_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            creg_q  <= creg_d;
            cmsb_q  <= cmsb_d;
            a_q     <= a_d;
            bx_q    <= bx_d;
            s_q     <= s_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.s    = s_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;
endmodule

// File: tb/tb_cla_addsub_seq.sv
// Bench for cla_addsub_seq: directed cases on 16/4 plus random sweeps over
// several WIDTH/BLK configurations against an arithmetic reference model.
module tb_cla_addsub_seq;
    typedef struct packed {
        logic [31:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  st = '0;
    logic [1:0]  drv_mode = '0;
    logic [31:0] drv_a = '0;
    logic [31:0] drv_b = '0;
    logic        drv_cin = 1'b0;

    logic        busy_o [5];
    logic        done_o [5];
    logic [31:0] s_o    [5];
    logic        cout_o [5];
    logic        ovf_o  [5];
    logic        zero_o [5];

    int n_checks = 0;
    int n_errors = 0;
    string cur = "";

    always #5 clk = ~clk;

    cla_addsub_seq_if #(.WIDTH(16)) if0 ();
    cla_addsub_seq_if #(.WIDTH(8))  if1 ();
    cla_addsub_seq_if #(.WIDTH(8))  if2 ();
    cla_addsub_seq_if #(.WIDTH(32)) if3 ();
    cla_addsub_seq_if #(.WIDTH(12)) if4 ();

    cla_addsub_seq #(.WIDTH(16), .BLK(4)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    cla_addsub_seq #(.WIDTH(8),  .BLK(8)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    cla_addsub_seq #(.WIDTH(8),  .BLK(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    cla_addsub_seq #(.WIDTH(32), .BLK(4)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));
    cla_addsub_seq #(.WIDTH(12), .BLK(3)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    assign if0.start = st[0]; assign if0.mode = drv_mode; assign if0.cin = drv_cin;
    assign if1.start = st[1]; assign if1.mode = drv_mode; assign if1.cin = drv_cin;
    assign if2.start = st[2]; assign if2.mode = drv_mode; assign if2.cin = drv_cin;
    assign if3.start = st[3]; assign if3.mode = drv_mode; assign if3.cin = drv_cin;
    assign if4.start = st[4]; assign if4.mode = drv_mode; assign if4.cin = drv_cin;
    assign if0.a = drv_a[15:0]; assign if0.b = drv_b[15:0];
    assign if1.a = drv_a[7:0];  assign if1.b = drv_b[7:0];
    assign if2.a = drv_a[7:0];  assign if2.b = drv_b[7:0];
    assign if3.a = drv_a;       assign if3.b = drv_b;
    assign if4.a = drv_a[11:0]; assign if4.b = drv_b[11:0];

    assign busy_o[0] = if0.busy; assign done_o[0] = if0.done; assign s_o[0] = 32'(if0.s);
    assign busy_o[1] = if1.busy; assign done_o[1] = if1.done; assign s_o[1] = 32'(if1.s);
    assign busy_o[2] = if2.busy; assign done_o[2] = if2.done; assign s_o[2] = 32'(if2.s);
    assign busy_o[3] = if3.busy; assign done_o[3] = if3.done; assign s_o[3] = if3.s;
    assign busy_o[4] = if4.busy; assign done_o[4] = if4.done; assign s_o[4] = 32'(if4.s);
    assign cout_o[0] = if0.cout; assign ovf_o[0] = if0.ovf; assign zero_o[0] = if0.zero;
    assign cout_o[1] = if1.cout; assign ovf_o[1] = if1.ovf; assign zero_o[1] = if1.zero;
    assign cout_o[2] = if2.cout; assign ovf_o[2] = if2.ovf; assign zero_o[2] = if2.zero;
    assign cout_o[3] = if3.cout; assign ovf_o[3] = if3.ovf; assign zero_o[3] = if3.zero;
    assign cout_o[4] = if4.cout; assign ovf_o[4] = if4.ovf; assign zero_o[4] = if4.zero;

    function automatic int unsigned cfg_width(input int k);
        case (k)
            0: return 16;
            1: return 8;
            2: return 8;
            3: return 32;
            default: return 12;
        endcase
    endfunction

    function automatic int unsigned cfg_nblk(input int k);
        case (k)
            0: return 4;
            1: return 1;
            2: return 8;
            3: return 8;
            default: return 4;
        endcase
    endfunction

    // Reference: plain wide-integer add of a, conditioned b and initial carry.
    function automatic res_t model(input int unsigned w, input logic [1:0] m,
                                   input logic [31:0] av, input logic [31:0] bv,
                                   input logic ci);
        res_t        r;
        logic [63:0] mask, aa, bb, sum;
        logic        c0;
        mask = (64'd1 << w) - 64'd1;
        aa   = {32'd0, av} & mask;
        bb   = {32'd0, bv} & mask;
        if (m[0]) bb = ~bb & mask;
        c0   = m[1] ? ci : m[0];
        sum  = aa + bb + 64'(c0);
        r.s    = 32'(sum & mask);
        r.cout = sum[w];
        r.ovf  = (aa[w-1] == bb[w-1]) && (sum[w-1] != aa[w-1]);
        r.zero = ((sum & mask) == 64'd0);
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("%s.u%0d", tag, k),
                  {32'd0, busy_o[k], done_o[k], cout_o[k], ovf_o[k], zero_o[k]} | {27'd0, s_o[k], 5'd0},
                  64'd0);
        end
    endtask

    // One operation on DUT k; optional disturbance pulses start and swaps inputs mid-flight.
    task automatic run_op(input int k, input logic [1:0] m, input logic [31:0] av,
                          input logic [31:0] bv, input logic ci, input res_t exp,
                          input bit disturb);
        int n;
        int busy_cnt;
        int unsigned nb;
        nb = cfg_nblk(k);
        @(negedge clk);
        drv_mode = m; drv_a = av; drv_b = bv; drv_cin = ci; st[k] = 1'b1;
        @(negedge clk);
        st[k] = 1'b0;
        n = 1;
        busy_cnt = 0;
        while (n <= 40 && !done_o[k]) begin
            busy_cnt += int'(busy_o[k]);
            if (disturb && n == 2) begin
                st[k] = 1'b1; drv_mode = ~m; drv_a = $urandom; drv_b = $urandom; drv_cin = ~ci;
            end else if (disturb && n == int'(nb) + 1) begin
                st[k] = 1'b1;
            end else if (disturb && n == 3) begin
                st[k] = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        st[k] = 1'b0;
        check({cur, ".lat"}, 64'(n), 64'(nb + 2));
        check({cur, ".busy"}, 64'(busy_cnt), 64'(nb + 1));
        check({cur, ".res"}, {27'd0, s_o[k], cout_o[k], ovf_o[k], zero_o[k]}, 64'(exp));
        @(negedge clk);
        check({cur, ".pulse"}, {62'd0, done_o[k], busy_o[k]}, 64'd0);
        check({cur, ".hold"}, {27'd0, s_o[k], cout_o[k], ovf_o[k], zero_o[k]}, 64'(exp));
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dones;
        int first_at;
        int last_at;
        int gap_bad;
        res_t r;

        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        cur = "add1";   run_op(0, 2'b00, 32'h1234, 32'h0FFF, 1'b0, '{32'h2233, 1'b0, 1'b0, 1'b0}, 1'b0);
        cur = "sub_brw"; run_op(0, 2'b01, 32'h0005, 32'h0007, 1'b0, '{32'hFFFE, 1'b0, 1'b0, 1'b0}, 1'b0);
        cur = "sub_ovf"; run_op(0, 2'b01, 32'h8000, 32'h0001, 1'b0, '{32'h7FFF, 1'b1, 1'b1, 1'b0}, 1'b0);
        cur = "sub_eq";  run_op(0, 2'b01, 32'hABCD, 32'hABCD, 1'b1, '{32'h0000, 1'b1, 1'b0, 1'b1}, 1'b0);
        cur = "adc";     run_op(0, 2'b10, 32'hFFFF, 32'h0000, 1'b1, '{32'h0000, 1'b1, 1'b0, 1'b1}, 1'b0);
        cur = "sbb";     run_op(0, 2'b11, 32'h0000, 32'h0000, 1'b0, '{32'hFFFF, 1'b0, 1'b0, 1'b0}, 1'b0);
        cur = "rip_ovf"; run_op(0, 2'b00, 32'h7FFF, 32'h0001, 1'b0, '{32'h8000, 1'b0, 1'b1, 1'b0}, 1'b0);
        cur = "rip_all"; run_op(0, 2'b00, 32'hFFFF, 32'h0001, 1'b0, '{32'h0000, 1'b1, 1'b0, 1'b1}, 1'b0);
        cur = "disturb"; run_op(0, 2'b00, 32'h1234, 32'h0FFF, 1'b0, '{32'h2233, 1'b0, 1'b0, 1'b0}, 1'b1);

        // Start held high: operations accepted back to back every NBLK+2 cycles.
        @(negedge clk);
        drv_mode = 2'b01; drv_a = 32'h00A0; drv_b = 32'h0001; drv_cin = 1'b0; st[0] = 1'b1;
        dones = 0; first_at = 0; last_at = 0; gap_bad = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 30) st[0] = 1'b0;
            if (done_o[0]) begin
                dones++;
                if (first_at == 0) first_at = n;
                else if (n - last_at != 6) gap_bad++;
                last_at = n;
                check($sformatf("hold_start.s%0d", dones), 64'(s_o[0]), 64'h009F);
            end
        end
        check("hold_start.count", 64'(dones), 64'd5);
        check("hold_start.first", 64'(first_at), 64'd6);
        check("hold_start.gap", 64'(gap_bad), 64'd0);
        repeat (4) @(negedge clk);

        // Reset in the second RUN cycle: outputs clear at once and no done follows.
        drv_mode = 2'b00; drv_a = 32'h0F0F; drv_b = 32'h0101; drv_cin = 1'b0; st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            dones += int'(done_o[0]);
        end
        check("midrst.nodone", 64'(dones), 64'd0);
        cur = "post_rst"; run_op(0, 2'b00, 32'h0F0F, 32'h0101, 1'b0, '{32'h1010, 1'b0, 1'b0, 1'b0}, 1'b0);

        // Random operations on every configuration.
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 40; i++) begin
                logic [1:0]  m;
                logic [31:0] av, bv;
                logic        ci;
                m  = 2'($urandom_range(0, 3));
                av = $urandom;
                bv = $urandom;
                ci = 1'($urandom);
                if (i % 8 == 0) begin av = 32'hFFFF_FFFF; bv = 32'd1; end
                if (i % 8 == 1) begin av = 32'h7FFF_FFFF >> (32 - cfg_width(k)); bv = av; end
                r = model(cfg_width(k), m, av, bv, ci);
                cur = $sformatf("rnd.u%0d.%0d", k, i);
                run_op(k, m, av, bv, ci, r, 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/cla_addsub_seq.md
Name: cla_addsub_seq

Overview:
- Parametrised, multi-cycle carry-lookahead adder/subtractor; successor to the 8-bit combinational add/sub unit.
- Processes one BLK-bit lookahead block per clock, keeping the inter-block carry in a register, so wide operands close timing at high clock rates.
- Supports ADD, SUB, ADC and SBB modes, with start/busy/done handshake and carry, overflow and zero flags.
- Sits between the operand register file and the result/flag registers of the datapath.

Parameters:
- WIDTH, 16, operand and result width in bits; must be an integer multiple of BLK.
- BLK, 4, lookahead block width, i.e. bits resolved per cycle; 1 <= BLK <= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- mode  input  2  00 ADD, 01 SUB, 10 ADC, 11 SBB; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- cin  input  1  carry-in for ADC/SBB; sampled with start; ignored for ADD/SUB.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse when the result is valid.
- s  output  WIDTH  result.
- cout  output  1  carry out of the MSB; for SUB/SBB, 1 = no borrow.
- ovf  output  1  signed two's-complement overflow.
- zero  output  1  high when s == 0.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, s, cout, ovf and zero are all 0; block index and carry register cleared. Reset mid-operation aborts the operation with no done pulse.
- NBLK = WIDTH/BLK; block index counter width = clog2(NBLK), minimum 1.
- Operand conditioning at start:
  - bx = b for ADD/ADC; bx = ~b for SUB/SBB.
  - Initial carry c0: ADD=0, SUB=1, ADC=cin, SBB=cin (cin=1 means no borrow in).
  - a, bx, c0 and mode are latched.
- States:
  - IDLE: start=1 latches operands, clears the result register, sets idx=0, moves to RUN, and sets busy=1 at the same edge.
  - RUN: each cycle computes block idx.
    - G = a_blk & bx_blk; P = a_blk ^ bx_blk.
    - Full lookahead carries within the block, from the carry register.
    - s[idx*BLK +: BLK] = P ^ {carries[BLK-2:0], creg}.
    - creg <= block carry-out.
    - If idx == NBLK-1, the FSM moves to DONE; otherwise idx increments.
  - DONE: done=1 for exactly this cycle and busy=0. Flags are registered:
    - cout = final carry.
    - ovf = carry into MSB XOR carry out of MSB.
    - zero = (s == 0).
    - Next state is IDLE unconditionally; start is not accepted in DONE.
- Latency: start sampled at edge k → done high in the cycle following edge k+NBLK+1. With WIDTH=16 and BLK=4, done is high 5 cycles after start is sampled.
- Throughput: one operation per NBLK+2 cycles.
- s, cout, ovf and zero hold their values from DONE until the next accepted start. At the start edge, s is cleared to 0 and the flags hold until DONE.
- start while busy or in DONE: ignored, with no effect on latched operands.
- Changes on a, b, mode or cin after the start edge: no effect.
- NBLK=1 (BLK=WIDTH): one RUN cycle, functionally equivalent to a registered single-block CLA.
- Lookahead must be correct for every bit; every carry term uses the correct P indices. A carry generated in block 0 must ripple through all upper propagate blocks (covered by test 4).

Test Plan (WIDTH=16, BLK=4 unless stated):
1. ADD: a=0x1234, b=0x0FFF, start for 1 cycle → busy high 5 cycles; done pulse exactly 1 cycle; s=0x2233, cout=0, ovf=0, zero=0.
2. SUB with borrow/overflow:
   - 0x0005-0x0007 → s=0xFFFE, cout=0, ovf=0.
   - 0x8000-0x0001 → s=0x7FFF, cout=1, ovf=1.
   - 0xABCD-0xABCD → s=0x0000, cout=1, zero=1.
3. ADC/SBB chaining:
   - ADC 0xFFFF+0x0000, cin=1 → s=0x0000, cout=1, zero=1.
   - SBB 0x0000-0x0000, cin=0 → s=0xFFFF, cout=0.
4. Full-length carry ripple: ADD 0x7FFF+0x0001 → s=0x8000, ovf=1, cout=0. ADD 0xFFFF+0x0001 → s=0x0000, cout=1, ovf=0, zero=1.
5. Handshake robustness:
   - Pulse start again while busy with different operands → ignored; the first result is delivered.
   - Hold start high continuously → one accepted operation per 6 cycles.
   - Change a/b mid-operation → no effect.
6. Reset and parameter sweep:
   - Assert rst_n=0 at RUN cycle 2 → all outputs 0 immediately; no done; next operation is correct.
   - Repeat random ADD/SUB/ADC/SBB against a golden model for (WIDTH, BLK) = (8,8), (8,1), (32,4), (12,3).
